// File: rtl/adder_pkg.sv
// Shared constants and state encoding for the burst accumulator.
// No logic; types and limits only.
// Not applicable (no handshakes).
package adder_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] SMAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SMIN = 16'h8000;
  localparam logic [DATA_W-1:0] UMAX = 16'hFFFF;

  // Accumulator control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : adder_pkg

// File: rtl/full_adder_16bit.sv
// 16-bit ripple adder with carry-out and two's-complement overflow.
// Purely combinational, zero cycles.
// No flow control; the result follows the inputs.
module full_adder_16bit
  import adder_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              overflow
);

  logic [DATA_W:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
  assign sum      = full_sum[DATA_W-1:0];
  assign cout     = full_sum[DATA_W];

  // Signed overflow: both operands share a sign that the result does not.
  assign overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule : full_adder_16bit

// File: rtl/adder_accumulator_16bit.sv
// Burst accumulator: sums len operands with sticky carry/overflow status.
// Result is visible one cycle after the last operand handshake.
// Operands are stalled outside ACCUM; the result holds until out_ready.
module adder_accumulator_16bit
  import adder_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              signed_mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] acc_out,
  output logic [LEN_W-1:0]  carry_cnt,
  output logic              ovf_sticky,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LEN_W-1:0]    carry_q, carry_d;
  logic                ovf_q, ovf_d;
  logic                mode_q, mode_d;

  logic [DATA_W-1:0]   add_sum;
  logic                add_cout;
  logic                add_ovf;
  logic [DATA_W-1:0]   next_acc;
  logic                range_err;
  logic                in_hs;

  // Adder sees the running total and the current operand.
  full_adder_16bit u_adder (
    .a        (acc_q),
    .b        (in_data),
    .cin      (1'b0),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (add_ovf)
  );

  // Handshake qualifiers derive only from registered state.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign in_hs     = in_valid && in_ready;

  assign acc_out    = acc_q;
  assign carry_cnt  = carry_q;
  assign ovf_sticky = ovf_q;

  // A range violation is signed overflow in signed bursts, carry-out otherwise.
  assign range_err = mode_q ? add_ovf : add_cout;

  // Saturation mux: clamp toward the side the running total was on.
  always_comb begin
    next_acc = add_sum;
    if (SATURATE) begin
      if (mode_q && add_ovf) begin
        next_acc = acc_q[DATA_W-1] ? SMIN : SMAX;
      end else if (!mode_q && add_cout) begin
        next_acc = UMAX;
      end
    end
  end

  // Burst control: load on start, accumulate on handshakes, hold until taken.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          carry_d = '0;
          ovf_d   = 1'b0;
          mode_d  = signed_mode;
          rem_d   = len;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_hs) begin
          acc_d = next_acc;
          rem_d = rem_q - LEN_W'(1);
          if (add_cout && (carry_q != '1)) begin
            carry_d = carry_q + LEN_W'(1);
          end
          if (range_err) begin
            ovf_d = 1'b1;
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
    end
  end

endmodule : adder_accumulator_16bit

// File: tb/tb_adder_accumulator_16bit.sv
// Bench for the burst accumulator: wrapping and saturating instances share stimulus.
// Checks on the falling edge, one cycle after inputs are applied.
// Exercises operand gaps, result stalls and mid-burst reset.
module tb_adder_accumulator_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        signed_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_0, out_valid_0, busy_0, ovf_0;
  logic        in_ready_1, out_valid_1, busy_1, ovf_1;
  logic [15:0] acc_0, acc_1;
  logic [7:0]  cc_0, cc_1;

  int checks = 0;
  int errors = 0;

  // Reference state per instance: index 0 wraps, index 1 saturates.
  int exp_acc [2];
  int exp_cc  [2];
  int exp_ovf [2];
  bit cur_mode;
  logic [15:0] ops [$];

  always #5 clk = ~clk;

  adder_accumulator_16bit #(.LEN_W(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_0),
    .out_valid(out_valid_0), .out_ready(out_ready), .acc_out(acc_0),
    .carry_cnt(cc_0), .ovf_sticky(ovf_0), .busy(busy_0)
  );

  adder_accumulator_16bit #(.LEN_W(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_1),
    .out_valid(out_valid_1), .out_ready(out_ready), .acc_out(acc_1),
    .carry_cnt(cc_1), .ovf_sticky(ovf_1), .busy(busy_1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Accept one operand into the reference for one instance.
  task automatic model_step(input int sat, input logic [15:0] b);
    int u, s;
    bit cy, ov;
    u  = exp_acc[sat] + int'(b);
    s  = to_signed(exp_acc[sat]) + to_signed(int'(b));
    cy = (u > 65535);
    ov = (s > 32767) || (s < -32768);
    if (cy && exp_cc[sat] < 255) exp_cc[sat]++;
    if (cur_mode ? ov : cy) exp_ovf[sat] = 1;
    if (sat == 1 && cur_mode && ov)       exp_acc[sat] = (s > 0) ? 32767 : 32768;
    else if (sat == 1 && !cur_mode && cy) exp_acc[sat] = 65535;
    else                                  exp_acc[sat] = u % 65536;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      exp_acc[i] = 0;
      exp_cc[i]  = 0;
      exp_ovf[i] = 0;
    end
  endtask

  task automatic check_data(input string tag);
    check({tag, "_acc0"}, acc_0, exp_acc[0]);
    check({tag, "_cc0"},  cc_0,  exp_cc[0]);
    check({tag, "_ovf0"}, ovf_0, exp_ovf[0]);
    check({tag, "_acc1"}, acc_1, exp_acc[1]);
    check({tag, "_cc1"},  cc_1,  exp_cc[1]);
    check({tag, "_ovf1"}, ovf_1, exp_ovf[1]);
  endtask

  task automatic check_ctrl(input string tag, input bit ovld, input bit irdy, input bit bsy);
    check({tag, "_ovld0"}, out_valid_0, ovld);
    check({tag, "_ovld1"}, out_valid_1, ovld);
    check({tag, "_irdy0"}, in_ready_0, irdy);
    check({tag, "_irdy1"}, in_ready_1, irdy);
    check({tag, "_busy0"}, busy_0, bsy);
    check({tag, "_busy1"}, busy_1, bsy);
  endtask

  // One full burst over ops[]; called and returns on a falling edge.
  task automatic run_burst(input int n, input bit mode, input bit gaps, input int stall);
    int idx;
    int budget;
    start = 1'b1;
    len = 8'(n);
    signed_mode = mode;
    cur_mode = mode;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    if (n == 0) begin
      check_ctrl("len0", 1'b1, 1'b0, 1'b1);
      check_data("len0");
    end else begin
      check_ctrl("load", 1'b0, 1'b1, 1'b1);
      idx = 0;
      budget = 0;
      while (idx < n && budget < 400) begin
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = in_valid ? ops[idx] : 16'($urandom);
        @(negedge clk);
        budget++;
        if (in_valid) begin
          model_step(0, ops[idx]);
          model_step(1, ops[idx]);
          idx++;
        end
        in_valid = 1'b0;
        check_data("part");
        check("part_ovld0", out_valid_0, idx == n);
        check("part_ovld1", out_valid_1, idx == n);
      end
      if (idx < n) check("timeout", idx, n);
    end
    for (int s = 0; s < stall; s++) begin
      start = 1'b1;
      len = 8'($urandom_range(0, 5));
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check_ctrl("stall", 1'b1, 1'b0, 1'b1);
      check_data("stall");
    end
    out_ready = 1'b1;
    start = 1'b1;
    len = 8'd3;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check_ctrl("exit", 1'b0, 1'b0, 1'b0);
    check_data("exit");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    #2;
    model_clear();
    check_ctrl("rst", 1'b0, 1'b0, 1'b0);
    check_data("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_ctrl("idle", 1'b0, 1'b0, 1'b0);

    ops = '{16'h0005, 16'h000A, 16'h03FF};
    run_burst(3, 1'b0, 1'b0, 0);
    check("t1_acc", acc_0, 16'h040E);
    check("t1_cc",  cc_0,  8'd0);
    check("t1_ovf", ovf_0, 1'b0);

    ops = '{16'h7FFF, 16'h0001};
    run_burst(2, 1'b1, 1'b0, 1);
    check("t2_acc", acc_0, 16'h8000);
    check("t2_ovf", ovf_0, 1'b1);
    check("t2_cc",  cc_0,  8'd0);

    ops = '{16'h8000, 16'h8000, 16'h0005};
    run_burst(3, 1'b1, 1'b1, 5);
    check("t3_acc", acc_1, 16'h8005);
    check("t3_ovf", ovf_1, 1'b1);
    check("t3_cc",  cc_1,  8'd1);

    ops = '{16'hFFFF, 16'hFFFF};
    run_burst(2, 1'b0, 1'b1, 2);
    check("t4_acc", acc_1, 16'hFFFF);
    check("t4_cc",  cc_1,  8'd1);
    check("t4_ovf", ovf_1, 1'b1);

    ops = {};
    run_burst(0, 1'b0, 1'b0, 1);
    check("t5_acc", acc_0, 16'h0000);

    // Reset after the first of four operands.
    start = 1'b1;
    len = 8'd4;
    signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_acc0", acc_0, 16'h1234);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_ctrl("arst", 1'b0, 1'b0, 1'b0);
    check_data("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_ctrl("arst_idle", 1'b0, 1'b0, 1'b0);

    ops = '{16'h0100, 16'h0020, 16'h0003};
    run_burst(3, 1'b0, 1'b1, 0);
    check("t6_acc", acc_0, 16'h0123);

    // Randomised bursts with corner-heavy operands.
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(0, 8);
      ops = {};
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 5))
          0: ops.push_back(16'h7FFF);
          1: ops.push_back(16'h8000);
          2: ops.push_back(16'hFFFF);
          3: ops.push_back(16'h0001);
          default: ops.push_back(16'($urandom));
        endcase
      end
      run_burst(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_adder_accumulator_16bit
